usb_packet_packer: RTL

Receive-side stage between the USB byte receiver and the 1 KiB USB packet buffer. It takes the de-stuffed payload byte stream of a DATA packet, including its trailing CRC16. It packs the bytes little-endian into 32-bit words and writes them into the packet buffer. At end of packet it checks the CRC16 and raises `got_packet` with the payload length, which sets `usb_packet_ready` and loads `usb_data_length`.

---
 rtl/usb_packet_packer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/usb_packet_packer.sv
// Packs de-stuffed USB DATA payload bytes (plus CRC16) little-endian into 32-bit packet buffer words.
// Latency: word write 1 cycle after its lane-3 byte; partial-word write 1 cycle after packet_end, verdict 2 cycles after.
// Backpressure: none upstream; writes are suppressed and the packet dropped while the core owns the buffer.
module usb_packet_packer #(
  parameter int BUFFER_SIZE   = 1024,
  parameter int ADDRESS_WIDTH = $clog2(BUFFER_SIZE / 4)
) (
  input  logic                     clk48,
  input  logic                     reset,
  input  logic                     packet_start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  input  logic                     packet_end,
  input  logic                     buffer_owned_by_core,
  output logic [ADDRESS_WIDTH-1:0] buffer_address,
  output logic [31:0]              buffer_write_value,
  output logic                     buffer_write,
  output logic                     got_packet,
  output logic [9:0]               data_length,
  output logic                     crc_error,
  output logic                     overflow
);

  // Byte counter must hold BUFFER_SIZE itself so a full buffer is distinguishable from empty.
  localparam int CW = $clog2(BUFFER_SIZE) + 1;
  localparam logic [CW-1:0]            FULL_COUNT = CW'(BUFFER_SIZE);
  localparam logic [CW-1:0]            CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]            CNT_TWO    = CW'(2);
  localparam logic [ADDRESS_WIDTH-1:0] WORD_ONE   = ADDRESS_WIDTH'(1);
  // Residual left in the reflected CRC16 register after a good payload and its inverted CRC.
  localparam logic [15:0]              CRC_GOOD   = 16'hB001;

  // Outputs are registered one edge ahead, so the FLUSH write is visible during FLUSH and the
  // verdict pulse is visible during CHECK.
  typedef enum logic [2:0] {IDLE, RECEIVE, FLUSH, CHECK, DISCARD} state_t;

  state_t                   state;
  logic [CW-1:0]            count;
  logic [ADDRESS_WIDTH-1:0] word_index;
  logic [31:0]              assembly;
  logic [15:0]              crc;

  logic [31:0]              byte_assembly;
  logic [15:0]              byte_crc;
  logic [CW-1:0]            byte_count;
  logic                     lane3;
  logic                     restart;

  // One byte of the reflected CRC16 (poly 0xA001), LSB first as on the wire.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // State the packer would hold after accepting the current byte.
  always_comb begin
    byte_assembly = assembly;
    byte_assembly[{count[1:0], 3'b000} +: 8] = byte_data;
    byte_crc   = crc16_byte(crc, byte_data);
    byte_count = count + CNT_ONE;
    lane3      = (count[1:0] == 2'b11);
    restart    = packet_start && (state == IDLE || state == RECEIVE || state == DISCARD);
  end

  // Packet FSM with its datapath and registered outputs.
  always_ff @(posedge clk48 or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      count              <= '0;
      word_index         <= '0;
      assembly           <= '0;
      crc                <= 16'hFFFF;
      buffer_address     <= '0;
      buffer_write_value <= '0;
      buffer_write       <= 1'b0;
      got_packet         <= 1'b0;
      data_length        <= '0;
      crc_error          <= 1'b0;
      overflow           <= 1'b0;
    end else begin
      buffer_write <= 1'b0;
      got_packet   <= 1'b0;
      crc_error    <= 1'b0;
      overflow     <= 1'b0;
      if (restart) begin
        // A new start always wins; an unfinished packet is dropped without any pulse.
        count      <= '0;
        word_index <= '0;
        assembly   <= '0;
        crc        <= 16'hFFFF;
        state      <= buffer_owned_by_core ? DISCARD : RECEIVE;
      end else begin
        case (state)
          IDLE: ;
          DISCARD: begin
            if (packet_end) state <= IDLE;
          end
          RECEIVE: begin
            if (buffer_owned_by_core) begin
              state <= packet_end ? IDLE : DISCARD;
            end else if (byte_valid && count == FULL_COUNT) begin
              overflow <= 1'b1;
              state    <= packet_end ? IDLE : DISCARD;
            end else begin
              if (byte_valid) begin
                crc   <= byte_crc;
                count <= byte_count;
                if (lane3) begin
                  buffer_write       <= 1'b1;
                  buffer_address     <= word_index;
                  buffer_write_value <= byte_assembly;
                  word_index         <= word_index + WORD_ONE;
                  assembly           <= '0;
                end else begin
                  assembly <= byte_assembly;
                end
              end
              if (packet_end) begin
                state <= FLUSH;
                // Partial last word; a same-cycle byte is already folded in, upper lanes stay 0.
                if (byte_valid ? !lane3 : (count[1:0] != 2'b00)) begin
                  buffer_write       <= 1'b1;
                  buffer_address     <= word_index;
                  buffer_write_value <= byte_valid ? byte_assembly : assembly;
                end
              end
            end
          end
          FLUSH: begin
            state <= CHECK;
            if (count >= CNT_TWO && crc == CRC_GOOD) begin
              got_packet  <= 1'b1;
              data_length <= 10'(count - CNT_TWO);
            end else begin
              crc_error <= 1'b1;
            end
          end
          CHECK: begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
